trigger_pulse_generator: RTL and testbench
==========================================

# trigger_pulse_generator

Downstream consumer of the digital edge detector's one-cycle `trigger` output. Once armed, the block turns a detected edge into a programmable burst on `pulse_out`: a delay, then `cfg_count` pulses of `cfg_width` cycles separated by `cfg_gap` cycles. The burst drives the glitch/fault output pin. Configuration words come from the serial register block and are already resynchronised into `sampleclk`.

## Interface
- No parameters.
- `sampleclk`  in  1  sole clock, all logic on its rising edge
- `reset`  in  1  synchronous, active-high reset
- `trigger_in`  in  1  one-cycle trigger pulse from the edge detector; level-sampled
- `arm`  in  1  one-cycle request to arm
- `disarm`  in  1  one-cycle abort/disarm request; wins over everything except `reset`
- `cfg_delay`  in  16  cycles from trigger to first pulse
- `cfg_width`  in  16  pulse high time in cycles; 0 is treated as 1
- `cfg_gap`  in  16  low time between pulses in cycles; 0 is treated as 1
- `cfg_count`  in  8  pulses per burst; 0 is treated as 1
- `cfg_invert`  in  1  output polarity; 1 = idle high, pulses low
- `cfg_auto_rearm`  in  1  1 = return to ARMED after a burst instead of IDLE
- `pulse_out`  out  1  registered burst output
- `armed`  out  1  high while in ARMED
- `busy`  out  1  high in DELAY, PULSE or GAP
- `done`  out  1  one-cycle strobe when a burst completes normally
- `trig_missed`  out  8  saturating count of triggers ignored while busy

## Operation
- State machine states are IDLE, ARMED, DELAY, PULSE and GAP. Reset enters IDLE.
- Reset values: `pulse_out`=0, `armed`=0, `busy`=0, `done`=0, `trig_missed`=0. All internal counters are 0.
- IDLE: `arm`=1 and `disarm`=0 moves to ARMED. `trigger_in` is ignored and not counted.
- ARMED: `trigger_in`=1 latches `cfg_delay`, `cfg_width`, `cfg_gap`, `cfg_count` and `cfg_invert` (after clamping). The FSM then moves to DELAY if delay>0, otherwise straight to PULSE.
- DELAY: a 16-bit down-counter loaded with the delay. On reaching the last cycle the FSM moves to PULSE.
- PULSE: `pulse_out` = ~latched invert. The FSM holds for the width in cycles, then decrements the remaining-pulse counter (8-bit).
  - Remaining > 0: go to GAP.
  - Remaining = 0: assert `done` for one cycle and go to ARMED if `cfg_auto_rearm` (live value at that edge) is 1, else IDLE.
- GAP: `pulse_out` = latched invert for the gap in cycles, then go to PULSE.
- Outside PULSE, `pulse_out` = invert level. The latched value applies during a burst; the live `cfg_invert` applies in IDLE and ARMED.
- `trigger_in`=1 in DELAY, PULSE or GAP has no effect on timing. It increments `trig_missed`, which saturates at 255.
- `trig_missed` is cleared by `reset`, or by an accepted `arm` in IDLE.
- `disarm`=1 in any state goes to IDLE at the next edge. `pulse_out` returns to the idle level at that edge, and `done` is not asserted.
- `arm` in ARMED, DELAY, PULSE or GAP is ignored.
- Config changes during a burst have no effect, because the values were latched at the trigger.

## Timing
- Trigger sampled at edge T: `busy` is high from edge T+1.
- First `pulse_out` active level appears at edge T+1+D, where D is the latched delay. Minimum latency is 1 cycle.
- Each pulse is active for exactly W edges. Each gap is inactive for exactly G edges.
- Total burst length from the first active edge is N·W + (N−1)·G cycles.
- `done` is high for the single cycle after the final pulse's last active cycle. `pulse_out` is idle and `busy` is low in that same cycle.
- `arm` accepted at edge A: `armed` is high from edge A+1. A trigger at edge A itself is ignored.
- Auto-rearm: a trigger one cycle after `done` is accepted.
- `reset` at any edge forces all outputs to their reset values at that edge.

## Test plan
- Arm; trigger with D=3, W=2, N=1, G=x → `pulse_out` high at edges T+4..T+5. `done` at T+6. Then `armed`=0 and state IDLE.
- D=0, W=0, N=0 → exactly one 1-cycle pulse at edge T+1. `done` at T+2.
- D=1, W=2, G=3, N=3, invert=1 → `pulse_out` low on T+2..3, T+7..8 and T+12..13, and high elsewhere. `done` at T+14.
- Triggers at T+1, T+2 and T+3 during a D=10 delay → burst timing unchanged and `trig_missed`=3. Then 300 busy triggers → `trig_missed` holds at 255. Re-arm → 0.
- `disarm` mid-PULSE → `pulse_out` idle at the next edge, `busy`=0, no `done`, and subsequent triggers are ignored until re-armed.
- Auto-rearm with N=1: two triggers spaced by the burst length + 1 → two complete bursts and two `done` strobes. Then assert `reset` mid-second-burst → all outputs 0 at that edge.

Source files
------------

// File: rtl/trigger_pulse_generator_if.sv
// Signal bundle between the trigger source / register block and the burst generator.
// The master side drives triggers, requests and configuration; the slave side returns status.
interface trigger_pulse_generator_if;
    logic        trigger_in;
    logic        arm;
    logic        disarm;
    logic [15:0] cfg_delay;
    logic [15:0] cfg_width;
    logic [15:0] cfg_gap;
    logic [7:0]  cfg_count;
    logic        cfg_invert;
    logic        cfg_auto_rearm;
    logic        pulse_out;
    logic        armed;
    logic        busy;
    logic        done;
    logic [7:0]  trig_missed;

    modport master (
        output trigger_in, arm, disarm,
        output cfg_delay, cfg_width, cfg_gap, cfg_count, cfg_invert, cfg_auto_rearm,
        input  pulse_out, armed, busy, done, trig_missed
    );

    modport slave (
        input  trigger_in, arm, disarm,
        input  cfg_delay, cfg_width, cfg_gap, cfg_count, cfg_invert, cfg_auto_rearm,
        output pulse_out, armed, busy, done, trig_missed
    );
endinterface

// File: rtl/trigger_pulse_generator.sv
// Turns an accepted trigger into a burst on pulse_out: a delay, then a train of
// programmable-width pulses separated by programmable gaps. All outputs are registered.
module trigger_pulse_generator (
    input  logic                     sampleclk,
    input  logic                     reset,
    trigger_pulse_generator_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ARMED, DELAY, PULSE, GAP} state_t;

    state_t      state, state_n;
    logic [15:0] dly_cnt, dly_n;
    logic [15:0] wid_cnt, wid_n;
    logic [15:0] gap_cnt, gap_n;
    logic [15:0] lat_width, lat_width_n;
    logic [15:0] lat_gap, lat_gap_n;
    logic        lat_invert, lat_invert_n;
    logic [7:0]  rem_cnt, rem_n;
    logic [7:0]  missed, missed_n;
    logic        done_n;
    logic        burst_n;
    logic        pulse_reg, armed_reg, busy_reg, done_reg;

    function automatic logic [15:0] clamp16(input logic [15:0] v);
        return (v == 16'd0) ? 16'd1 : v;
    endfunction

    function automatic logic [7:0] clamp8(input logic [7:0] v);
        return (v == 8'd0) ? 8'd1 : v;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_comb begin
        state_n      = state;
        dly_n        = dly_cnt;
        wid_n        = wid_cnt;
        gap_n        = gap_cnt;
        rem_n        = rem_cnt;
        lat_width_n  = lat_width;
        lat_gap_n    = lat_gap;
        lat_invert_n = lat_invert;
        missed_n     = missed;
        done_n       = 1'b0;

        case (state)
            IDLE: begin
                if (bus.arm) begin
                    state_n  = ARMED;
                    missed_n = 8'd0;
                end
            end
            ARMED: begin
                if (bus.trigger_in) begin
                    lat_width_n  = clamp16(bus.cfg_width);
                    lat_gap_n    = clamp16(bus.cfg_gap);
                    lat_invert_n = bus.cfg_invert;
                    rem_n        = clamp8(bus.cfg_count);
                    wid_n        = clamp16(bus.cfg_width);
                    dly_n        = bus.cfg_delay;
                    state_n      = (bus.cfg_delay != 16'd0) ? DELAY : PULSE;
                end
            end
            DELAY: begin
                if (dly_cnt <= 16'd1) begin
                    state_n = PULSE;
                    wid_n   = lat_width;
                end else begin
                    dly_n = dly_cnt - 16'd1;
                end
            end
            PULSE: begin
                if (wid_cnt <= 16'd1) begin
                    rem_n = rem_cnt - 8'd1;
                    if (rem_cnt <= 8'd1) begin
                        done_n  = 1'b1;
                        state_n = bus.cfg_auto_rearm ? ARMED : IDLE;
                    end else begin
                        state_n = GAP;
                        gap_n   = lat_gap;
                    end
                end else begin
                    wid_n = wid_cnt - 16'd1;
                end
            end
            GAP: begin
                if (gap_cnt <= 16'd1) begin
                    state_n = PULSE;
                    wid_n   = lat_width;
                end else begin
                    gap_n = gap_cnt - 16'd1;
                end
            end
            default: state_n = IDLE;
        endcase

        // Triggers arriving mid-burst never disturb timing; they are only tallied.
        if (bus.trigger_in && (state == DELAY || state == PULSE || state == GAP))
            missed_n = sat_inc8(missed);

        // Abort overrides any progress made this cycle, including a completing burst.
        if (bus.disarm) begin
            state_n  = IDLE;
            done_n   = 1'b0;
            missed_n = missed;
        end

        burst_n = (state_n == DELAY) || (state_n == PULSE) || (state_n == GAP);
    end

    always_ff @(posedge sampleclk) begin
        if (reset) begin
            state      <= IDLE;
            dly_cnt    <= 16'd0;
            wid_cnt    <= 16'd0;
            gap_cnt    <= 16'd0;
            lat_width  <= 16'd0;
            lat_gap    <= 16'd0;
            lat_invert <= 1'b0;
            rem_cnt    <= 8'd0;
            missed     <= 8'd0;
            pulse_reg  <= 1'b0;
            armed_reg  <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state      <= state_n;
            dly_cnt    <= dly_n;
            wid_cnt    <= wid_n;
            gap_cnt    <= gap_n;
            lat_width  <= lat_width_n;
            lat_gap    <= lat_gap_n;
            lat_invert <= lat_invert_n;
            rem_cnt    <= rem_n;
            missed     <= missed_n;
            // Latched polarity inside a burst, live polarity while idle or armed.
            pulse_reg  <= burst_n ? (lat_invert_n ^ (state_n == PULSE)) : bus.cfg_invert;
            armed_reg  <= (state_n == ARMED);
            busy_reg   <= burst_n;
            done_reg   <= done_n;
        end
    end

    assign bus.pulse_out   = pulse_reg;
    assign bus.armed       = armed_reg;
    assign bus.busy        = busy_reg;
    assign bus.done        = done_reg;
    assign bus.trig_missed = missed;
endmodule

// File: tb/tb_trigger_pulse_generator.sv
// Bench for trigger_pulse_generator: each burst's expected per-cycle outputs are queued
// from a closed-form timing model when the trigger is driven, then popped cycle by cycle.
module tb_trigger_pulse_generator;
    logic clk = 1'b0;
    logic reset;

    trigger_pulse_generator_if bus();

    trigger_pulse_generator dut (
        .sampleclk(clk),
        .reset    (reset),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   k;
        logic pulse;
        logic busy;
        logic done;
        logic armed;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Expected outputs for observation k after the trigger edge (k=1 is the value registered at it).
    function automatic void push_burst(input int d, input int w, input int g, input int n,
                                       input logic inv, input logic auto_r);
        exp_t e;
        int   wc, gc, nc, len, j, last;
        wc   = (w == 0) ? 1 : w;
        gc   = (g == 0) ? 1 : g;
        nc   = (n == 0) ? 1 : n;
        len  = nc * wc + (nc - 1) * gc;
        last = d + len + 1 + (auto_r ? 0 : 1);
        for (int k = 1; k <= last; k++) begin
            j       = k - 1 - d;
            e.k     = k;
            e.busy  = (k <= d + len);
            e.done  = (k == d + len + 1);
            e.pulse = inv ^ ((j >= 0) && (j < len) && ((j % (wc + gc)) < wc));
            e.armed = (k > d + len) ? auto_r : 1'b0;
            exp_q.push_back(e);
        end
    endfunction

    task automatic do_arm();
        bus.arm = 1'b1;
        @(negedge clk);
        bus.arm = 1'b0;
    endtask

    // Fires a trigger now and scores the burst; optional busy-time triggers and an abort
    // (1 = disarm, 2 = reset) injected right after observation abort_at.
    task automatic run_burst(input string name, input int d, input int w, input int g,
                             input int n, input logic inv, input logic auto_r,
                             input int miss_from, input int miss_to,
                             input int abort_kind, input int abort_at);
        exp_t e;
        bus.cfg_delay      = 16'(d);
        bus.cfg_width      = 16'(w);
        bus.cfg_gap        = 16'(g);
        bus.cfg_count      = 8'(n);
        bus.cfg_invert     = inv;
        bus.cfg_auto_rearm = auto_r;
        bus.trigger_in     = 1'b1;
        push_burst(d, w, g, n, inv, auto_r);
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            if (e.k == 1) begin
                bus.cfg_delay = 16'hBEEF;
                bus.cfg_width = 16'd7;
                bus.cfg_gap   = 16'd9;
                bus.cfg_count = 8'd5;
            end
            checks++;
            if (bus.pulse_out !== e.pulse) begin
                failures++;
                $display("FAIL %s k=%0d pulse_out got %b want %b", name, e.k, bus.pulse_out, e.pulse);
            end
            checks++;
            if (bus.busy !== e.busy) begin
                failures++;
                $display("FAIL %s k=%0d busy got %b want %b", name, e.k, bus.busy, e.busy);
            end
            checks++;
            if (bus.done !== e.done) begin
                failures++;
                $display("FAIL %s k=%0d done got %b want %b", name, e.k, bus.done, e.done);
            end
            checks++;
            if (bus.armed !== e.armed) begin
                failures++;
                $display("FAIL %s k=%0d armed got %b want %b", name, e.k, bus.armed, e.armed);
            end
            reset          = 1'b0;
            bus.disarm     = 1'b0;
            bus.trigger_in = (e.k >= miss_from) && (e.k <= miss_to);
            if (abort_kind != 0 && e.k == abort_at) begin
                exp_q.delete();
                if (abort_kind == 1) begin
                    bus.disarm = 1'b1;
                    for (int i = 1; i <= 3; i++)
                        exp_q.push_back('{k: abort_at + i, pulse: inv, busy: 1'b0, done: 1'b0, armed: 1'b0});
                end else begin
                    reset = 1'b1;
                    exp_q.push_back('{k: abort_at + 1, pulse: 1'b0, busy: 1'b0, done: 1'b0, armed: 1'b0});
                end
            end
        end
        bus.trigger_in = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.pulse_out, bus.armed, bus.busy, bus.done} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_outputs got %b want 0000", {bus.pulse_out, bus.armed, bus.busy, bus.done});
        end
        checks++;
        if (bus.trig_missed !== 8'd0) begin
            failures++;
            $display("FAIL reset_missed got %0d want 0", bus.trig_missed);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        // A trigger on the same edge as the arm must be ignored.
        bus.arm        = 1'b1;
        bus.trigger_in = 1'b1;
        @(negedge clk);
        bus.arm        = 1'b0;
        bus.trigger_in = 1'b0;
        checks++;
        if (bus.armed !== 1'b1 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL arm_with_trigger armed/busy got %b%b want 10", bus.armed, bus.busy);
        end
        run_burst("single", 3, 2, 5, 1, 1'b0, 1'b0, 0, -1, 0, 0);
        bus.trigger_in = 1'b1;
        @(negedge clk);
        bus.trigger_in = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.armed !== 1'b0) begin
            failures++;
            $display("FAIL idle_trigger busy/armed got %b%b want 00", bus.busy, bus.armed);
        end
    endtask

    task automatic test_minimum();
        do_arm();
        run_burst("minimum", 0, 0, 0, 0, 1'b0, 1'b0, 0, -1, 0, 0);
    endtask

    task automatic test_invert_train();
        do_arm();
        run_burst("invert_train", 1, 2, 3, 3, 1'b1, 1'b0, 0, -1, 0, 0);
        bus.cfg_invert = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_missed();
        do_arm();
        run_burst("missed3", 10, 2, 1, 1, 1'b0, 1'b0, 1, 3, 0, 0);
        checks++;
        if (bus.trig_missed !== 8'd3) begin
            failures++;
            $display("FAIL missed_three got %0d want 3", bus.trig_missed);
        end
        do_arm();
        checks++;
        if (bus.trig_missed !== 8'd0) begin
            failures++;
            $display("FAIL missed_clear_on_arm got %0d want 0", bus.trig_missed);
        end
        run_burst("missed300", 400, 1, 1, 1, 1'b0, 1'b0, 1, 300, 0, 0);
        checks++;
        if (bus.trig_missed !== 8'd255) begin
            failures++;
            $display("FAIL missed_saturate got %0d want 255", bus.trig_missed);
        end
        do_arm();
        checks++;
        if (bus.trig_missed !== 8'd0 || bus.armed !== 1'b1) begin
            failures++;
            $display("FAIL rearm_clear missed/armed got %0d/%b want 0/1", bus.trig_missed, bus.armed);
        end
    endtask

    task automatic test_disarm();
        run_burst("disarm", 2, 10, 1, 1, 1'b0, 1'b0, 0, -1, 1, 5);
        bus.trigger_in = 1'b1;
        @(negedge clk);
        bus.trigger_in = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.pulse_out !== 1'b0 || bus.trig_missed !== 8'd0) begin
            failures++;
            $display("FAIL post_disarm busy/pulse/missed got %b/%b/%0d want 0/0/0",
                     bus.busy, bus.pulse_out, bus.trig_missed);
        end
    endtask

    task automatic test_back_to_back();
        do_arm();
        run_burst("auto_first", 2, 3, 1, 1, 1'b0, 1'b1, 0, -1, 0, 0);
        run_burst("auto_second", 2, 3, 1, 1, 1'b0, 1'b1, 0, -1, 2, 3);
        checks++;
        if (bus.trig_missed !== 8'd0) begin
            failures++;
            $display("FAIL reset_mid_burst missed got %0d want 0", bus.trig_missed);
        end
    endtask

    initial begin
        reset              = 1'b1;
        bus.trigger_in     = 1'b0;
        bus.arm            = 1'b0;
        bus.disarm         = 1'b0;
        bus.cfg_delay      = 16'd0;
        bus.cfg_width      = 16'd0;
        bus.cfg_gap        = 16'd0;
        bus.cfg_count      = 8'd0;
        bus.cfg_invert     = 1'b0;
        bus.cfg_auto_rearm = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_minimum();
        test_invert_train();
        test_missed();
        test_disarm();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
